udp_oe_tx_chan_sched: RTL and testbench

- Packet-granular round-robin scheduler sharing the single Ethernet TX path of the UDP offload engine among NUM_CHAN per-channel TX packet streams.
- Sits between the per-channel UDP packetizers and the MAC TX interface.
- Driven by the CSR-controlled per-channel enable and tx_rst bits.
- Aborts packets cleanly when a channel is reset or stalls mid-packet.

---
 rtl/udp_oe_tx_chan_sched_if.sv | 31 +++
 rtl/udp_oe_tx_chan_sched.sv | 154 +++++++++++++++
 tb/tb_udp_oe_tx_chan_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_oe_tx_chan_sched_if.sv
// Stream bundle between the per-channel UDP packetizers, the TX scheduler and the MAC.
// The slave modport is the scheduler's view; the master modport is the surrounding fabric.
interface udp_oe_tx_chan_sched_if #(
  parameter int NUM_CHAN = 2,
  parameter int DATA_W   = 64
);
  localparam int KEEP_W = DATA_W / 8;

  logic [NUM_CHAN-1:0]        in_tvalid;
  logic [NUM_CHAN-1:0]        in_tready;
  logic [NUM_CHAN*DATA_W-1:0] in_tdata;
  logic [NUM_CHAN*KEEP_W-1:0] in_tkeep;
  logic [NUM_CHAN-1:0]        in_tlast;

  logic              out_tvalid;
  logic              out_tready;
  logic [DATA_W-1:0] out_tdata;
  logic [KEEP_W-1:0] out_tkeep;
  logic              out_tlast;
  logic              out_tuser;

  modport master (
    output in_tvalid, in_tdata, in_tkeep, in_tlast, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser
  );

  modport slave (
    input  in_tvalid, in_tdata, in_tkeep, in_tlast, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser
  );
endinterface

// File: rtl/udp_oe_tx_chan_sched.sv
// Packet-granular round-robin scheduler muxing NUM_CHAN TX streams onto the MAC,
// with clean abort (tuser-marked terminating beat) on channel reset/disable or stall.
module udp_oe_tx_chan_sched #(
  parameter int NUM_CHAN      = 2,
  parameter int DATA_W        = 64,
  parameter int STALL_TIMEOUT = 1024,
  localparam int KEEP_W       = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CHAN-1:0]    chan_en,
  input  logic [NUM_CHAN-1:0]    chan_tx_rst,
  udp_oe_tx_chan_sched_if.slave  bus,
  output logic [3:0]             cur_grant,
  output logic                   busy,
  output logic [15:0]            abort_cnt
);
  typedef enum logic [1:0] {ARB, XFER, ABORT} state_t;

  localparam int CNT_W = $clog2(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [3:0]        last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  stall_cnt, stall_nxt;
  logic [15:0]       abort_cnt_nxt;

  logic [NUM_CHAN-1:0] eligible;
  logic [15:0]         elig16;
  logic                arb_found;
  logic [3:0]          arb_pick, scan;

  logic              sel_vld, sel_last, sel_en, sel_rst;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              abort_trig, pass_ready;
  logic [NUM_CHAN-1:0] ready_vec;

  assign eligible = bus.in_tvalid & chan_en & ~chan_tx_rst;
  assign elig16   = 16'(eligible);

  // Round-robin search starting one past the previous winner, wrapping at NUM_CHAN.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = last_grant;
    scan      = last_grant;
    for (int k = 0; k < NUM_CHAN; k++) begin
      scan = (scan == 4'(NUM_CHAN - 1)) ? 4'd0 : scan + 4'd1;
      if (!arb_found && elig16[scan]) begin
        arb_found = 1'b1;
        arb_pick  = scan;
      end
    end
  end

  // Constant-index mux of the granted channel's signals.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_en   = 1'b0;
    sel_rst  = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (4'(i) == last_grant) begin
        sel_vld  = bus.in_tvalid[i];
        sel_last = bus.in_tlast[i];
        sel_en   = chan_en[i];
        sel_rst  = chan_tx_rst[i];
        sel_data = bus.in_tdata[i*DATA_W +: DATA_W];
        sel_keep = bus.in_tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  assign abort_trig = sel_rst | ~sel_en | (stall_cnt == STALL_MAX);

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    stall_nxt      = stall_cnt;
    abort_cnt_nxt  = abort_cnt;
    pass_ready     = 1'b0;
    busy           = 1'b0;
    bus.out_tvalid = 1'b0;
    bus.out_tdata  = '0;
    bus.out_tkeep  = '0;
    bus.out_tlast  = 1'b0;
    bus.out_tuser  = 1'b0;
    unique case (state)
      ARB: begin
        stall_nxt = '0;
        if (arb_found) begin
          last_grant_nxt = arb_pick;
          state_nxt      = XFER;
        end
      end
      XFER: begin
        busy = 1'b1;
        if (abort_trig) begin
          stall_nxt = '0;
          state_nxt = ABORT;
        end else begin
          bus.out_tvalid = sel_vld;
          bus.out_tdata  = sel_data;
          bus.out_tkeep  = sel_keep;
          bus.out_tlast  = sel_last;
          pass_ready     = bus.out_tready;
          stall_nxt      = sel_vld ? '0 : stall_cnt + 1'b1;
          if (sel_vld && bus.out_tready && sel_last) state_nxt = ARB;
        end
      end
      ABORT: begin
        busy           = 1'b1;
        bus.out_tvalid = 1'b1;
        bus.out_tlast  = 1'b1;
        bus.out_tuser  = 1'b1;
        if (bus.out_tready) begin
          if (abort_cnt != 16'hFFFF) abort_cnt_nxt = abort_cnt + 16'd1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (4'(i) == last_grant) ready_vec[i] = pass_ready;
    end
  end

  assign bus.in_tready = ready_vec;
  assign cur_grant     = busy ? last_grant : 4'd0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      last_grant <= 4'(NUM_CHAN - 1);
      stall_cnt  <= '0;
      abort_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      stall_cnt  <= stall_nxt;
      abort_cnt  <= abort_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_udp_oe_tx_chan_sched.sv
// Directed bench for udp_oe_tx_chan_sched: fairness, backpressure, aborts, masking, async reset.
module tb_udp_oe_tx_chan_sched;
  localparam int NC = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC-1:0] chan_en;
  logic [NC-1:0] chan_tx_rst;
  logic [3:0]    cur_grant;
  logic          busy;
  logic [15:0]   abort_cnt;

  udp_oe_tx_chan_sched_if #(.NUM_CHAN(NC), .DATA_W(DW)) bus ();

  udp_oe_tx_chan_sched #(.NUM_CHAN(NC), .DATA_W(DW), .STALL_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chan_en     (chan_en),
    .chan_tx_rst (chan_tx_rst),
    .bus         (bus),
    .cur_grant   (cur_grant),
    .busy        (busy),
    .abort_cnt   (abort_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic [3:0]  gnt;
    int          t;
  } beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    s_len [NC];
  int    s_beat[NC];
  int    s_pkt [NC];
  int    s_npk [NC];
  bit    s_hold[NC];
  bit    bp_mode;
  bit    fired;
  int    ch1_beats;
  beat_t mon_q[$];

  function automatic logic [63:0] pat(input int ch, input int pkt, input int beat);
    return {16'(ch), 16'h0, 16'(pkt), 16'(beat)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int ch = 0; ch < NC; ch++) begin
      bus.in_tvalid[ch]         = (s_npk[ch] > 0) && !s_hold[ch];
      bus.in_tdata[ch*DW +: DW] = pat(ch, s_pkt[ch], s_beat[ch]);
      bus.in_tkeep[ch*8 +: 8]   = (s_beat[ch] == s_len[ch] - 1) ? 8'h3F : 8'hFF;
      bus.in_tlast[ch]          = (s_beat[ch] == s_len[ch] - 1);
    end
    bus.out_tready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  endtask

  // One clock: log the MAC beat and advance sources on their pre-edge handshakes.
  task automatic cycle();
    beat_t b;
    bit    hs[NC];
    if (bus.out_tvalid && bus.out_tready) begin
      b.data = bus.out_tdata; b.keep = bus.out_tkeep; b.last = bus.out_tlast;
      b.user = bus.out_tuser; b.gnt = cur_grant; b.t = cyc;
      mon_q.push_back(b);
    end
    for (int ch = 0; ch < NC; ch++) hs[ch] = bus.in_tvalid[ch] && bus.in_tready[ch];
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < NC; ch++) begin
      if (hs[ch]) begin
        if (s_beat[ch] == s_len[ch] - 1) begin
          s_beat[ch] = 0;
          s_pkt[ch]++;
          s_npk[ch]--;
        end else begin
          s_beat[ch]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    chan_en     = '0;
    chan_tx_rst = '0;
    bp_mode     = 1'b0;
    for (int ch = 0; ch < NC; ch++) begin
      s_len[ch] = 1; s_beat[ch] = 0; s_pkt[ch] = 0; s_npk[ch] = 0; s_hold[ch] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    mon_q.delete();
    drive();
    #1;
  endtask

  task automatic check_beat(input string tag, input int idx, input int ch, input int pkt,
                            input int beat, input int len);
    if (idx < mon_q.size()) begin
      check({tag, "_data"}, mon_q[idx].data, pat(ch, pkt, beat));
      check({tag, "_keep"}, 64'(mon_q[idx].keep), (beat == len - 1) ? 64'h3F : 64'hFF);
      check({tag, "_last"}, 64'(mon_q[idx].last), 64'(beat == len - 1));
      check({tag, "_user"}, 64'(mon_q[idx].user), 64'h0);
      check({tag, "_gnt"},  64'(mon_q[idx].gnt),  64'(ch));
    end
  endtask

  initial begin
    // Reset state, observed while reset_n is still low.
    reset_n = 1'b0;
    chan_en = '1;
    chan_tx_rst = '0;
    bp_mode = 1'b0;
    for (int ch = 0; ch < NC; ch++) begin
      s_len[ch] = 2; s_beat[ch] = 0; s_pkt[ch] = 0; s_npk[ch] = 1; s_hold[ch] = 1'b0;
    end
    drive();
    #12;
    check("rst_out_tvalid", 64'(bus.out_tvalid), 64'h0);
    check("rst_in_tready",  64'(bus.in_tready),  64'h0);
    check("rst_busy",       64'(busy),           64'h0);
    check("rst_grant",      64'(cur_grant),      64'h0);
    check("rst_abort_cnt",  64'(abort_cnt),      64'h0);
    check("rst_out_tuser",  64'(bus.out_tuser),  64'h0);

    // Fairness: two 3-beat packets per channel, alternating with one bubble.
    do_reset();
    chan_en = 2'b11;
    s_len = '{3, 3};
    s_npk = '{2, 2};
    drive(); #1;
    run(22);
    check("t1_nbeats", 64'(mon_q.size()), 64'd12);
    for (int k = 0; k < 12; k++)
      check_beat($sformatf("t1_b%0d", k), k, (k / 3) % 2, k / 6, k % 3, 3);
    for (int p = 1; p < 4; p++)
      if (3 * p < mon_q.size())
        check($sformatf("t1_gap%0d", p), 64'(mon_q[3*p].t - mon_q[3*p-1].t), 64'd2);

    // Backpressure: 4-beat packet on ch1 with out_tready 1,0,0,1,...
    do_reset();
    chan_en = 2'b11;
    s_len[1] = 4;
    s_npk[1] = 1;
    bp_mode = 1'b1;
    drive(); #1;
    run(20);
    check("t2_nbeats", 64'(mon_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) check_beat($sformatf("t2_b%0d", k), k, 1, 0, k, 4);
    check("t2_abort_cnt", 64'(abort_cnt), 64'h0);

    // Mid-packet channel reset after 2 of 5 beats; ch1 gets the next grant.
    do_reset();
    chan_en = 2'b11;
    s_len = '{5, 2};
    s_npk = '{1, 1};
    fired = 1'b0;
    drive(); #1;
    for (int n = 0; n < 16; n++) begin
      cycle();
      if (!fired && mon_q.size() == 2) begin
        chan_tx_rst = 2'b01;
        fired = 1'b1;
        #1;
      end
    end
    check("t3_nbeats", 64'(mon_q.size()), 64'd5);
    check_beat("t3_b0", 0, 0, 0, 0, 5);
    check_beat("t3_b1", 1, 0, 0, 1, 5);
    if (mon_q.size() > 2) begin
      check("t3_ab_data", mon_q[2].data, 64'h0);
      check("t3_ab_keep", 64'(mon_q[2].keep), 64'h0);
      check("t3_ab_last", 64'(mon_q[2].last), 64'h1);
      check("t3_ab_user", 64'(mon_q[2].user), 64'h1);
      check("t3_ab_gap",  64'(mon_q[2].t - mon_q[1].t), 64'd2);
    end
    check_beat("t3_b3", 3, 1, 0, 0, 2);
    check_beat("t3_b4", 4, 1, 0, 1, 2);
    check("t3_abort_cnt", 64'(abort_cnt), 64'd1);

    // Stall timeout (8): one beat, then tvalid drops; abort beat 8 cycles after the drop.
    do_reset();
    chan_en = 2'b11;
    s_len[0] = 4;
    s_npk[0] = 1;
    fired = 1'b0;
    drive(); #1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (!fired && mon_q.size() == 1) begin
        s_hold[0] = 1'b1;
        fired = 1'b1;
        drive(); #1;
      end
    end
    check("t4_nbeats", 64'(mon_q.size()), 64'd2);
    check_beat("t4_b0", 0, 0, 0, 0, 4);
    if (mon_q.size() > 1) begin
      check("t4_ab_delay", 64'(mon_q[1].t - mon_q[0].t), 64'd9);
      check("t4_ab_user",  64'(mon_q[1].user), 64'h1);
      check("t4_ab_keep",  64'(mon_q[1].keep), 64'h0);
    end
    check("t4_in_tready0", 64'(bus.in_tready[0]), 64'h0);
    check("t4_busy",       64'(busy), 64'h0);
    check("t4_abort_cnt",  64'(abort_cnt), 64'd1);

    // Disabled channel: chan_en=01 with both offering packets.
    do_reset();
    chan_en = 2'b01;
    s_len = '{2, 2};
    s_npk = '{2, 2};
    drive(); #1;
    run(15);
    check("t5_nbeats", 64'(mon_q.size()), 64'd4);
    ch1_beats = 0;
    foreach (mon_q[k]) if (mon_q[k].gnt != 4'd0) ch1_beats++;
    check("t5_ch1_beats", 64'(ch1_beats), 64'd0);
    for (int k = 0; k < 4; k++) check_beat($sformatf("t5_b%0d", k), k, 0, k / 2, k % 2, 2);

    // Channel held in TX reset is never granted.
    do_reset();
    chan_en = 2'b11;
    chan_tx_rst = 2'b10;
    s_len[1] = 2;
    s_npk[1] = 1;
    drive(); #1;
    run(10);
    check("t5r_nbeats", 64'(mon_q.size()), 64'd0);
    check("t5r_busy",   64'(busy), 64'h0);

    // Async reset during beat 2 of a ch0 packet; arbitration restarts at ch0.
    do_reset();
    chan_en = 2'b11;
    s_len = '{4, 2};
    s_npk = '{1, 1};
    drive(); #1;
    run(2);
    check("t6_pre_beats", 64'(mon_q.size()), 64'd1);
    check("t6_pre_tvalid", 64'(bus.out_tvalid), 64'h1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(bus.out_tvalid), 64'h0);
    check("t6_rst_busy",   64'(busy), 64'h0);
    check("t6_rst_tready", 64'(bus.in_tready), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_q.delete();
    cyc = 0;
    drive(); #1;
    run(6);
    check("t6_post_nbeats", 64'(mon_q.size() > 0), 64'h1);
    if (mon_q.size() > 0) begin
      check("t6_post_gnt",  64'(mon_q[0].gnt), 64'h0);
      check("t6_post_data", mon_q[0].data, pat(0, 0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
